// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with 64-bit cycle/instret counters and a forwarded read port
`ifndef REG_BUS
`define REG_BUS 32
`endif
`ifndef CSR_ADDR_BUS
`define CSR_ADDR_BUS 12
`endif
module csr_file (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     excp_csr_we_i,
    input  logic [`CSR_ADDR_BUS-1:0] excp_csr_waddr_i,
    input  logic [`REG_BUS-1:0]      excp_csr_wdata_i,
    input  logic                     exu_csr_we_i,
    input  logic [`CSR_ADDR_BUS-1:0] exu_csr_waddr_i,
    input  logic [`REG_BUS-1:0]      exu_csr_wdata_i,
    input  logic [`CSR_ADDR_BUS-1:0] csr_raddr_i,
    output logic [`REG_BUS-1:0]      csr_rdata_o,
    input  logic                     inst_retire_i,
    input  logic                     timer_irq_i,
    output logic [`REG_BUS-1:0]      csr_mtvec_o,
    output logic [`REG_BUS-1:0]      csr_mepc_o,
    output logic [`REG_BUS-1:0]      csr_mstatus_o
);
    logic                     we, wr_ok;
    logic [`CSR_ADDR_BUS-1:0] waddr;
    logic [`REG_BUS-1:0]      wdata, wval, rd;
    logic [`REG_BUS-1:0]      mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
    logic [`REG_BUS-1:0]      mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [`REG_BUS-1:0]      mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0]              mcycle_q, mcycle_d, minstret_q, minstret_d;
    always_comb begin
        we    = excp_csr_we_i | exu_csr_we_i;
        waddr = excp_csr_we_i ? excp_csr_waddr_i : exu_csr_waddr_i;
        wdata = excp_csr_we_i ? excp_csr_wdata_i : exu_csr_wdata_i;
        wval  = waddr == 12'h300 ? (wdata & 32'h0000_0088) | 32'h0000_1800 :
                waddr == 12'h304 ? wdata & 32'h0000_0080 :
                (waddr == 12'h305 || waddr == 12'h341) ? wdata & ~32'h3 : wdata;
        wr_ok = we && (waddr inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                     12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82});
        mstatus_d  = (wr_ok && waddr == 12'h300) ? wval : mstatus_q;
        mie_d      = (wr_ok && waddr == 12'h304) ? wval : mie_q;
        mtvec_d    = (wr_ok && waddr == 12'h305) ? wval : mtvec_q;
        mscratch_d = (wr_ok && waddr == 12'h340) ? wval : mscratch_q;
        mepc_d     = (wr_ok && waddr == 12'h341) ? wval : mepc_q;
        mcause_d   = (wr_ok && waddr == 12'h342) ? wval : mcause_q;
        mtval_d    = (wr_ok && waddr == 12'h343) ? wval : mtval_q;
        // A half-write freezes the other half for that edge: no increment, no carry
        mcycle_d   = (wr_ok && waddr == 12'hB00) ? {mcycle_q[63:32], wval} :
                     (wr_ok && waddr == 12'hB80) ? {wval, mcycle_q[31:0]} : mcycle_q + 64'd1;
        minstret_d = (wr_ok && waddr == 12'hB02) ? {minstret_q[63:32], wval} :
                     (wr_ok && waddr == 12'hB82) ? {wval, minstret_q[31:0]} :
                     minstret_q + {63'd0, inst_retire_i};
        case (csr_raddr_i)
            12'h300: rd = mstatus_q;
            12'h301: rd = 32'h4000_1100;
            12'h304: rd = mie_q;
            12'h305: rd = mtvec_q;
            12'h340: rd = mscratch_q;
            12'h341: rd = mepc_q;
            12'h342: rd = mcause_q;
            12'h343: rd = mtval_q;
            12'h344: rd = {24'h0, timer_irq_i, 7'h0};
            12'hB00: rd = mcycle_q[31:0];
            12'hB80: rd = mcycle_q[63:32];
            12'hB02: rd = minstret_q[31:0];
            12'hB82: rd = minstret_q[63:32];
            default: rd = '0;
        endcase
        csr_rdata_o = (wr_ok && waddr == csr_raddr_i) ? wval : rd;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q  <= 32'h0000_1800;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
    assign csr_mtvec_o   = mtvec_q;
    assign csr_mepc_o    = mepc_q;
    assign csr_mstatus_o = mstatus_q;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed checks of csr_file reset, masking, arbitration, forwarding and counters
module tb_csr_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        excp_csr_we_i, exu_csr_we_i, inst_retire_i, timer_irq_i;
    logic [11:0] excp_csr_waddr_i, exu_csr_waddr_i, csr_raddr_i;
    logic [31:0] excp_csr_wdata_i, exu_csr_wdata_i;
    logic [31:0] csr_rdata_o, csr_mtvec_o, csr_mepc_o, csr_mstatus_o;
    int          n_cmp = 0;
    int          n_err = 0;
    csr_file dut (
        .clk(clk), .rst_n(rst_n),
        .excp_csr_we_i(excp_csr_we_i), .excp_csr_waddr_i(excp_csr_waddr_i), .excp_csr_wdata_i(excp_csr_wdata_i),
        .exu_csr_we_i(exu_csr_we_i), .exu_csr_waddr_i(exu_csr_waddr_i), .exu_csr_wdata_i(exu_csr_wdata_i),
        .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
        .inst_retire_i(inst_retire_i), .timer_irq_i(timer_irq_i),
        .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o), .csr_mstatus_o(csr_mstatus_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr_i = a;
        #1;
        chk(tag, csr_rdata_o, exp);
    endtask
    task automatic excp(input logic [11:0] a, input logic [31:0] d);
        excp_csr_we_i = 1'b1;
        excp_csr_waddr_i = a;
        excp_csr_wdata_i = d;
    endtask
    task automatic exu(input logic [11:0] a, input logic [31:0] d);
        exu_csr_we_i = 1'b1;
        exu_csr_waddr_i = a;
        exu_csr_wdata_i = d;
    endtask
    task automatic idle();
        excp_csr_we_i = 1'b0;
        exu_csr_we_i = 1'b0;
    endtask
    initial begin
        logic [5:0] ret_pat;
        ret_pat = 6'b001101;
        rst_n = 1'b0;
        idle();
        excp_csr_waddr_i = '0; excp_csr_wdata_i = '0;
        exu_csr_waddr_i = '0; exu_csr_wdata_i = '0;
        csr_raddr_i = '0; inst_retire_i = 1'b0; timer_irq_i = 1'b0;
        tick(); tick();
        chk("rst_mstatus_o", csr_mstatus_o, 32'h0000_1800);
        chk("rst_mtvec_o", csr_mtvec_o, 32'h0);
        chk("rst_mepc_o", csr_mepc_o, 32'h0);
        rd("rst_mcycle", 12'hB00, 32'h0);
        rst_n = 1'b1;
        rd("mstatus", 12'h300, 32'h0000_1800);
        rd("misa", 12'h301, 32'h4000_1100);
        for (int i = 1; i <= 5; i++) begin
            tick();
            rd($sformatf("mcycle_%0d", i), 12'hB00, i);
        end
        // exception unit trap sequence on three consecutive cycles
        excp(12'h341, 32'h8000_0106);
        rd("fwd_mepc", 12'h341, 32'h8000_0104);
        tick();
        chk("mepc_o", csr_mepc_o, 32'h8000_0104);
        excp(12'h300, 32'hFFFF_FFFF);
        rd("fwd_mstatus", 12'h300, 32'h0000_1888);
        tick();
        chk("mstatus_o", csr_mstatus_o, 32'h0000_1888);
        excp(12'h342, 32'h8000_0007);
        tick();
        idle();
        rd("mcause", 12'h342, 32'h8000_0007);
        chk("mepc_o_hold", csr_mepc_o, 32'h8000_0104);
        // simultaneous writes: exception wins
        excp(12'h305, 32'h0000_0100);
        exu(12'h305, 32'h0000_0200);
        rd("fwd_arb_mtvec", 12'h305, 32'h0000_0100);
        tick();
        idle();
        chk("arb_mtvec_o", csr_mtvec_o, 32'h0000_0100);
        exu(12'h305, 32'h0000_0203);
        tick();
        idle();
        chk("mtvec_mode_mask", csr_mtvec_o, 32'h0000_0200);
        exu(12'h340, 32'hDEAD_BEEF);
        tick();
        exu(12'h304, 32'hFFFF_FFFF);
        tick();
        exu(12'h343, 32'h1234_5678);
        tick();
        idle();
        rd("mscratch", 12'h340, 32'hDEAD_BEEF);
        rd("mie_mask", 12'h304, 32'h0000_0080);
        rd("mtval", 12'h343, 32'h1234_5678);
        // counter wrap and half-write isolation
        exu(12'hB00, 32'hFFFF_FFFF);
        tick();
        exu(12'hB80, 32'hFFFF_FFFF);
        tick();
        idle();
        rd("preload_lo", 12'hB00, 32'hFFFF_FFFF);
        rd("preload_hi", 12'hB80, 32'hFFFF_FFFF);
        tick(); tick();
        rd("wrap_lo", 12'hB00, 32'h0000_0001);
        rd("wrap_hi", 12'hB80, 32'h0000_0000);
        exu(12'hB80, 32'h0000_0005);
        tick();
        exu(12'hB00, 32'h0000_0000);
        tick();
        idle();
        rd("wr_lo_lo", 12'hB00, 32'h0);
        rd("wr_lo_hi", 12'hB80, 32'h5);
        tick();
        rd("resume_lo", 12'hB00, 32'h1);
        // retire pulses on 3 of 6 cycles
        for (int i = 0; i < 6; i++) begin
            inst_retire_i = ret_pat[i];
            tick();
        end
        inst_retire_i = 1'b0;
        rd("minstret", 12'hB02, 32'h3);
        rd("minstreth", 12'hB82, 32'h0);
        // read-only and unimplemented addresses ignore writes
        exu(12'hF14, 32'hFFFF_FFFF);
        rd("mhartid_fwd", 12'hF14, 32'h0);
        tick();
        excp(12'h301, 32'h0);
        rd("misa_fwd", 12'h301, 32'h4000_1100);
        tick();
        exu(12'h7C0, 32'h0000_1234);
        tick();
        idle();
        rd("mhartid", 12'hF14, 32'h0);
        rd("misa_ro", 12'h301, 32'h4000_1100);
        rd("unimpl", 12'h7C0, 32'h0);
        timer_irq_i = 1'b1;
        rd("mip_set", 12'h344, 32'h0000_0080);
        timer_irq_i = 1'b0;
        rd("mip_clr", 12'h344, 32'h0);
        // reset lands while the mstatus write is in flight
        excp(12'h341, 32'h0000_0200);
        tick();
        excp(12'h300, 32'h0000_0000);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mstatus", csr_mstatus_o, 32'h0000_1800);
        chk("rst_mid_mepc", csr_mepc_o, 32'h0);
        chk("rst_mid_mtvec", csr_mtvec_o, 32'h0);
        idle();
        rd("rst_mid_mcycle", 12'hB00, 32'h0);
        tick();
        chk("rst_hold_mstatus", csr_mstatus_o, 32'h0000_1800);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
